// File: rtl/husky_cw310_top.sv
// husky_cw310_top: USB register file driving a one-shot glitch generator, target IO, user IO and a target clock
module husky_cw310_top #(
    parameter logic [7:0] pIDENT    = 8'h5A,
    parameter int         pOFFSET_W = 16
) (
    input  logic       clk_usb,
    input  logic       reset,
    inout  wire  [7:0] USB_Data,
    input  logic [7:0] USB_Addr,
    input  logic [6:0] USB_Addr_Bytecount,
    input  logic       USB_RDn,
    input  logic       USB_WRn,
    input  logic       USB_CEn,
    output logic       LED_ADC,
    output logic       LED_GLITCH,
    output logic       LED_ARMED,
    output logic       LED_CAP,
    output logic       glitch_out,
    output logic       glitch_clk,
    inout  wire        target_io1,
    inout  wire        target_io2,
    inout  wire        target_io3,
    inout  wire        target_io4,
    input  logic       target_hs1,
    output logic       target_hs2,
    inout  wire        AUXIO,
    inout  wire  [7:0] USERIO_D
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_PULSE = 2'd3;

    logic                 r_wrn;
    logic                 r_arm;
    logic                 r_manual;
    logic                 r_falling;
    logic [pOFFSET_W-1:0] r_offset;
    logic [7:0]           r_width;
    logic [7:0]           r_io_cfg;
    logic [7:0]           r_user_oe;
    logic [7:0]           r_user_out;
    logic [7:0]           r_gcount;
    logic                 r_clken;
    logic                 r_hs2;
    logic                 r_io4_s1;
    logic                 r_io4_s2;
    logic                 r_io4_s3;
    logic [1:0]           r_state;
    logic [pOFFSET_W-1:0] r_cnt;
    logic [7:0]           r_wcnt;
    logic                 r_glitch;
    logic [16:0]          r_stretch;
    logic [23:0]          r_free;

    logic                 w_wr;
    logic                 w_bc0;
    logic                 w_bc1;
    logic                 w_wr0;
    logic                 w_wr_ctrl;
    logic                 w_edge;
    logic                 w_trig;
    logic                 w_enter;
    logic [1:0]           w_next;
    logic [15:0]          w_off16;
    logic [7:0]           w_rd;

    assign w_bc0     = (USB_Addr_Bytecount == 7'd0);
    assign w_bc1     = (USB_Addr_Bytecount == 7'd1);
    assign w_wr      = r_wrn && !USB_WRn && !USB_CEn;
    assign w_wr0     = w_wr && w_bc0;
    assign w_wr_ctrl = w_wr0 && (USB_Addr == 8'h01);
    assign w_off16   = 16'(r_offset);
    assign w_edge    = r_falling ? (r_io4_s3 && !r_io4_s2) : (!r_io4_s3 && r_io4_s2);
    assign w_trig    = w_edge || r_manual;
    assign w_enter   = (w_next == ST_PULSE) && (r_state != ST_PULSE);

    assign glitch_clk = clk_usb;
    assign glitch_out = r_glitch;
    assign target_hs2 = r_hs2;
    assign LED_ARMED  = (r_state == ST_ARMED);
    assign LED_CAP    = (r_state == ST_WAIT) || (r_state == ST_PULSE);
    assign LED_GLITCH = |r_stretch;
    assign LED_ADC    = r_free[23];

    assign USB_Data   = (!USB_CEn && !USB_RDn) ? w_rd : 8'hzz;
    assign target_io1 = r_io_cfg[0] ? r_io_cfg[4] : 1'bz;
    assign target_io2 = r_io_cfg[1] ? r_io_cfg[5] : 1'bz;
    assign target_io3 = r_io_cfg[2] ? r_io_cfg[6] : 1'bz;
    assign target_io4 = r_io_cfg[3] ? r_io_cfg[7] : 1'bz;

    genvar j;
    generate
        for (j = 0; j < 8; j++) begin : g_userio
            assign USERIO_D[j] = r_user_oe[j] ? r_user_out[j] : 1'bz;
        end
    endgenerate

    // Read mux: only byte 0 exists except for OFFSET, everything else reads zero
    always_comb begin
        w_rd = 8'h00;
        if (w_bc0) begin
            case (USB_Addr)
                8'h00:   w_rd = pIDENT;
                8'h01:   w_rd = {5'b0, r_falling, 1'b0, r_arm};
                8'h02:   w_rd = w_off16[7:0];
                8'h03:   w_rd = r_width;
                8'h04:   w_rd = r_io_cfg;
                8'h05:   w_rd = {2'b00, target_hs1, AUXIO, target_io4, target_io3, target_io2, target_io1};
                8'h06:   w_rd = r_user_oe;
                8'h07:   w_rd = r_user_out;
                8'h08:   w_rd = USERIO_D;
                8'h09:   w_rd = r_gcount;
                8'h0A:   w_rd = {7'b0, r_clken};
                default: w_rd = 8'h00;
            endcase
        end else if (w_bc1 && (USB_Addr == 8'h02)) begin
            w_rd = w_off16[15:8];
        end
    end

    // Register file writes; arm auto-clear on pulse entry beats a coinciding host write
    always_ff @(posedge clk_usb) begin
        if (reset) begin
            r_wrn      <= 1'b0;
            r_arm      <= 1'b0;
            r_manual   <= 1'b0;
            r_falling  <= 1'b0;
            r_offset   <= '0;
            r_width    <= 8'h00;
            r_io_cfg   <= 8'h00;
            r_user_oe  <= 8'h00;
            r_user_out <= 8'h00;
            r_gcount   <= 8'h00;
            r_clken    <= 1'b0;
        end else begin
            r_wrn    <= USB_WRn;
            r_manual <= w_wr_ctrl && USB_Data[1];
            if (w_enter) r_arm <= 1'b0;
            else if (w_wr_ctrl) r_arm <= USB_Data[0];
            if (w_wr_ctrl) r_falling <= USB_Data[2];
            if (w_enter) r_gcount <= r_gcount + 8'd1;
            if (w_wr0 && (USB_Addr == 8'h02)) r_offset <= pOFFSET_W'({w_off16[15:8], USB_Data});
            if (w_wr && w_bc1 && (USB_Addr == 8'h02)) r_offset <= pOFFSET_W'({USB_Data, w_off16[7:0]});
            if (w_wr0 && (USB_Addr == 8'h03)) r_width <= USB_Data;
            if (w_wr0 && (USB_Addr == 8'h04)) r_io_cfg <= USB_Data;
            if (w_wr0 && (USB_Addr == 8'h06)) r_user_oe <= USB_Data;
            if (w_wr0 && (USB_Addr == 8'h07)) r_user_out <= USB_Data;
            if (w_wr0 && (USB_Addr == 8'h0A)) r_clken <= USB_Data[0];
        end
    end

    // Trigger synchronizer plus one extra stage for edge detection at its output
    always_ff @(posedge clk_usb) begin
        if (reset) begin
            r_io4_s1 <= 1'b0;
            r_io4_s2 <= 1'b0;
            r_io4_s3 <= 1'b0;
        end else begin
            r_io4_s1 <= target_io4;
            r_io4_s2 <= r_io4_s1;
            r_io4_s3 <= r_io4_s2;
        end
    end

    // Glitch FSM next state; a zero offset skips WAIT so the pulse starts right after the trigger cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = r_arm ? ST_ARMED : ST_IDLE;
            ST_ARMED: w_next = !r_arm ? ST_IDLE : !w_trig ? ST_ARMED : (r_offset == '0) ? ST_PULSE : ST_WAIT;
            ST_WAIT:  w_next = (r_cnt == pOFFSET_W'(1)) ? ST_PULSE : ST_WAIT;
            default:  w_next = (r_wcnt == 8'd1) ? ST_IDLE : ST_PULSE;
        endcase
    end

    // Glitch FSM state, offset and width counters, registered pulse output
    always_ff @(posedge clk_usb) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_wcnt   <= 8'h00;
            r_glitch <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_glitch <= (w_next == ST_PULSE);
            if (r_state == ST_ARMED) r_cnt <= r_offset;
            else if (r_state == ST_WAIT) r_cnt <= r_cnt - pOFFSET_W'(1);
            if (w_enter) r_wcnt <= (r_width == 8'h00) ? 8'd1 : r_width;
            else if (r_state == ST_PULSE) r_wcnt <= r_wcnt - 8'd1;
        end
    end

    // Glitch LED stretcher, free-running activity counter and divided target clock
    always_ff @(posedge clk_usb) begin
        if (reset) begin
            r_stretch <= 17'h0;
            r_free    <= 24'h0;
            r_hs2     <= 1'b0;
        end else begin
            r_free <= r_free + 24'd1;
            r_hs2  <= r_clken ? !r_hs2 : 1'b0;
            if (r_glitch) r_stretch <= 17'h10000;
            else if (|r_stretch) r_stretch <= r_stretch - 17'd1;
        end
    end

endmodule

// File: tb/tb_husky_cw310_top.sv
// tb_husky_cw310_top: scoreboard bench for register access, glitch timing, IO and target clock
module tb_husky_cw310_top;

    logic       clk_usb = 1'b0;
    logic       reset   = 1'b1;
    wire  [7:0] USB_Data;
    logic [7:0] usb_addr = 8'h00;
    logic [6:0] usb_bc   = 7'd0;
    logic       usb_rdn  = 1'b1;
    logic       usb_wrn  = 1'b1;
    logic       usb_cen  = 1'b1;
    logic [7:0] d_val    = 8'h00;
    logic       d_drv    = 1'b0;
    wire        led_adc, led_glitch, led_armed, led_cap;
    wire        glitch_out, glitch_clk, target_hs2;
    wire        target_io1, target_io2, target_io3, target_io4;
    logic [4:1] io_drv   = 4'b1000;
    logic [4:1] io_val   = 4'b0000;
    logic       target_hs1 = 1'b0;
    wire        AUXIO;
    logic       aux_drv  = 1'b1;
    logic       aux_val  = 1'b0;
    wire  [7:0] USERIO_D;
    logic [7:0] u_drv    = 8'h00;
    logic [7:0] u_val    = 8'h00;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         gcnt  = 0;
    logic [7:0] rd_q[$];
    logic       g_q[$];

    assign USB_Data   = d_drv ? d_val : 8'hzz;
    assign target_io1 = io_drv[1] ? io_val[1] : 1'bz;
    assign target_io2 = io_drv[2] ? io_val[2] : 1'bz;
    assign target_io3 = io_drv[3] ? io_val[3] : 1'bz;
    assign target_io4 = io_drv[4] ? io_val[4] : 1'bz;
    assign AUXIO      = aux_drv ? aux_val : 1'bz;

    genvar k;
    generate
        for (k = 0; k < 8; k++) begin : g_udrv
            assign USERIO_D[k] = u_drv[k] ? u_val[k] : 1'bz;
        end
    endgenerate

    husky_cw310_top dut (
        .clk_usb(clk_usb), .reset(reset), .USB_Data(USB_Data), .USB_Addr(usb_addr),
        .USB_Addr_Bytecount(usb_bc), .USB_RDn(usb_rdn), .USB_WRn(usb_wrn), .USB_CEn(usb_cen),
        .LED_ADC(led_adc), .LED_GLITCH(led_glitch), .LED_ARMED(led_armed), .LED_CAP(led_cap),
        .glitch_out(glitch_out), .glitch_clk(glitch_clk),
        .target_io1(target_io1), .target_io2(target_io2), .target_io3(target_io3), .target_io4(target_io4),
        .target_hs1(target_hs1), .target_hs2(target_hs2), .AUXIO(AUXIO), .USERIO_D(USERIO_D)
    );

    always #5 clk_usb = ~clk_usb;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic usb_wr(input logic [7:0] a, input logic [6:0] b, input logic [7:0] d);
        @(negedge clk_usb);
        usb_addr = a; usb_bc = b; d_val = d; d_drv = 1'b1; usb_cen = 1'b0; usb_wrn = 1'b0;
        @(negedge clk_usb);
        usb_wrn = 1'b1; usb_cen = 1'b1; d_drv = 1'b0;
    endtask

    task automatic usb_rd(input string tag, input logic [7:0] a, input logic [6:0] b, input logic [7:0] exp);
        rd_q.push_back(exp);
        @(negedge clk_usb);
        usb_addr = a; usb_bc = b; usb_cen = 1'b0; usb_rdn = 1'b0;
        #2;
        chk(tag, USB_Data, rd_q.pop_front());
        usb_rdn = 1'b1; usb_cen = 1'b1;
    endtask

    task automatic exp_pulse(input int s, input int w, input int n);
        for (int i = 0; i < n; i++) g_q.push_back(i >= s && i < s + w);
    endtask

    task automatic run_g(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk(tag, glitch_out, g_q.pop_front());
            @(negedge clk_usb);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk_usb);
        chk("rst_glitch", glitch_out, 0);
        chk("rst_led_armed", led_armed, 0);
        chk("rst_led_cap", led_cap, 0);
        chk("rst_led_glitch", led_glitch, 0);
        chk("rst_led_adc", led_adc, 0);
        chk("rst_hs2", target_hs2, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk_usb);

        usb_rd("ident", 8'h00, 7'd0, 8'h5A);
        usb_rd("unmapped", 8'h3F, 7'd0, 8'h00);
        usb_rd("ident_bc1", 8'h00, 7'd1, 8'h00);
        usb_wr(8'h00, 7'd0, 8'hFF);
        usb_rd("ident_ro", 8'h00, 7'd0, 8'h5A);
        usb_wr(8'h3F, 7'd0, 8'h12);
        usb_rd("unmapped_wr", 8'h3F, 7'd0, 8'h00);
        usb_wr(8'h09, 7'd0, 8'h44);
        usb_rd("gcount_ro", 8'h09, 7'd0, 8'h00);

        usb_wr(8'h02, 7'd0, 8'h34);
        usb_wr(8'h02, 7'd1, 8'h12);
        usb_rd("offset_b0", 8'h02, 7'd0, 8'h34);
        usb_rd("offset_b1", 8'h02, 7'd1, 8'h12);
        usb_rd("offset_b2", 8'h02, 7'd2, 8'h00);
        usb_wr(8'h03, 7'd0, 8'h02);
        usb_wr(8'h03, 7'd1, 8'h77);
        usb_rd("width", 8'h03, 7'd0, 8'h02);
        usb_rd("width_bc1", 8'h03, 7'd1, 8'h00);
        usb_wr(8'h01, 7'd0, 8'h06);
        usb_rd("ctrl_manual_rd0", 8'h01, 7'd0, 8'h04);
        usb_wr(8'h01, 7'd0, 8'h00);
        usb_rd("ctrl_clear", 8'h01, 7'd0, 8'h00);

        usb_wr(8'h04, 7'd0, 8'h31);
        usb_rd("io_cfg", 8'h04, 7'd0, 8'h31);
        io_drv = 4'b1110; io_val = 4'b0100; aux_val = 1'b1; target_hs1 = 1'b0;
        @(negedge clk_usb);
        chk("io1_drive", target_io1, 1);
        usb_rd("io_in_a", 8'h05, 7'd0, 8'h15);
        target_hs1 = 1'b1; aux_val = 1'b0;
        usb_rd("io_in_b", 8'h05, 7'd0, 8'h25);
        usb_wr(8'h04, 7'd0, 8'h00);
        io_drv = 4'b1000; io_val = 4'b0000; target_hs1 = 1'b0;

        usb_wr(8'h06, 7'd0, 8'h0F);
        usb_wr(8'h07, 7'd0, 8'hA5);
        u_drv = 8'hF0; u_val = 8'hC0;
        usb_rd("userio_in", 8'h08, 7'd0, 8'hC5);
        usb_rd("userio_oe", 8'h06, 7'd0, 8'h0F);
        usb_rd("userio_out", 8'h07, 7'd0, 8'hA5);
        u_drv = 8'h00;
        usb_wr(8'h06, 7'd0, 8'h00);

        usb_wr(8'h0A, 7'd0, 8'h01);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk_usb);
            chk("hs2_toggle", target_hs2, i % 2);
        end
        usb_rd("clkctrl", 8'h0A, 7'd0, 8'h01);
        usb_wr(8'h0A, 7'd0, 8'h00);
        @(negedge clk_usb);
        for (int i = 0; i < 4; i++) begin
            chk("hs2_hold", target_hs2, 0);
            @(negedge clk_usb);
        end

        usb_wr(8'h01, 7'd0, 8'h01);
        @(negedge clk_usb);
        chk("armed_led", led_armed, 1);
        usb_wr(8'h01, 7'd0, 8'h00);
        @(negedge clk_usb);
        chk("disarm_led", led_armed, 0);

        usb_wr(8'h02, 7'd0, 8'h03);
        usb_wr(8'h02, 7'd1, 8'h00);
        usb_wr(8'h03, 7'd0, 8'h02);
        usb_wr(8'h01, 7'd0, 8'h01);
        @(negedge clk_usb);
        chk("armed_led2", led_armed, 1);
        io_val[4] = 1'b1;
        exp_pulse(6, 2, 10);
        gcnt++;
        run_g("pulse_off3_w2", 10);
        usb_rd("gcount_1", 8'h09, 7'd0, 8'(gcnt));
        usb_rd("arm_oneshot", 8'h01, 7'd0, 8'h00);
        chk("led_glitch", led_glitch, 1);
        chk("led_armed_after", led_armed, 0);

        usb_wr(8'h02, 7'd0, 8'h00);
        usb_wr(8'h03, 7'd0, 8'h00);
        usb_wr(8'h01, 7'd0, 8'h01);
        usb_wr(8'h01, 7'd0, 8'h03);
        exp_pulse(1, 1, 6);
        gcnt++;
        run_g("manual_w0", 6);
        usb_rd("ctrl_after_manual", 8'h01, 7'd0, 8'h00);

        io_val[4] = 1'b0;
        repeat (4) @(negedge clk_usb);
        usb_wr(8'h02, 7'd0, 8'h0A);
        usb_wr(8'h03, 7'd0, 8'h01);
        usb_wr(8'h01, 7'd0, 8'h01);
        @(negedge clk_usb);
        exp_pulse(13, 1, 20);
        gcnt++;
        for (int i = 0; i < 20; i++) begin
            if (i == 0) io_val[4] = 1'b1;
            if (i == 3) io_val[4] = 1'b0;
            if (i == 5) io_val[4] = 1'b1;
            if (i == 8) chk("led_cap_wait", led_cap, 1);
            chk("double_edge", glitch_out, g_q.pop_front());
            @(negedge clk_usb);
        end
        usb_rd("gcount_3", 8'h09, 7'd0, 8'(gcnt));

        usb_wr(8'h02, 7'd0, 8'h00);
        usb_wr(8'h01, 7'd0, 8'h05);
        @(negedge clk_usb);
        io_val[4] = 1'b0;
        exp_pulse(3, 1, 6);
        gcnt++;
        run_g("falling_edge", 6);

        while (gcnt < 256) begin
            usb_wr(8'h01, 7'd0, 8'h01);
            usb_wr(8'h01, 7'd0, 8'h03);
            repeat (3) @(negedge clk_usb);
            gcnt++;
            if (gcnt == 255) usb_rd("gcount_ff", 8'h09, 7'd0, 8'hFF);
        end
        usb_rd("gcount_wrap", 8'h09, 7'd0, 8'(gcnt));

        usb_wr(8'h03, 7'd0, 8'd20);
        usb_wr(8'h01, 7'd0, 8'h01);
        usb_wr(8'h01, 7'd0, 8'h03);
        @(negedge clk_usb);
        chk("long_pulse_a", glitch_out, 1);
        @(negedge clk_usb);
        chk("long_pulse_b", glitch_out, 1);
        reset = 1'b1;
        @(negedge clk_usb);
        chk("reset_drop", glitch_out, 0);
        chk("reset_led_glitch", led_glitch, 0);
        chk("reset_led_cap", led_cap, 0);
        chk("reset_hs2", target_hs2, 0);
        @(negedge clk_usb);
        reset = 1'b0;
        repeat (2) @(negedge clk_usb);
        usb_rd("reset_width", 8'h03, 7'd0, 8'h00);
        usb_rd("reset_gcount", 8'h09, 7'd0, 8'h00);
        usb_rd("reset_ctrl", 8'h01, 7'd0, 8'h00);
        usb_rd("reset_ident", 8'h00, 7'd0, 8'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
